// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg : opcodes, ALU encodings and state/class enums | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_AND   = 6'h01;
  localparam logic [5:0] OP_ADDI  = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h12;
  localparam logic [5:0] OP_LOAD  = 6'h0D;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h01;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_AND  = 3'd2,
    CLS_ADDI = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5,
    CLS_LOAD = 3'd6,
    CLS_ILL  = 3'd7
  } iclass_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ----------------------------------------------------------------------------
// ctrl_decode : combinational op/func -> instruction class        | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output iclass_e    cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = CLS_ILL;
    unique case (op_i)
      OP_RTYPE: begin
        if (func_i == FN_ADD)      cls_o = CLS_ADD;
        else if (func_i == FN_NOP) cls_o = CLS_NOP;
        else                       cls_o = CLS_ILL;
      end
      OP_AND:  cls_o = CLS_AND;
      OP_ADDI: cls_o = CLS_ADDI;
      OP_BEQ:  cls_o = CLS_BEQ;
      OP_J:    cls_o = CLS_J;
      OP_LOAD: cls_o = CLS_LOAD;
      default: cls_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl : PC/IR owner and per-instruction sequencing FSM | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int PC_W  = 6,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  inst_addr,
  input  logic [31:0]      inst,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [IMM_W-1:0] imm,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             reg_dst_rd,
  output logic             mem_to_reg,
  output logic             mem_req,
  output logic             halt
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [1:0]      alu_op_q;
  logic            alu_src_imm_q;
  logic            reg_write_q;
  logic            reg_dst_rd_q;
  logic            mem_to_reg_q;
  logic            mem_req_q;
  logic            halt_q;

  iclass_e         cls;
  logic            illegal;

  ctrl_decode u_decode (
    .op_i      (ir_q[31:26]),
    .func_i    (ir_q[25:20]),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  // Outputs are loaded on entry to the state that owns them, so every
  // strobe comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      alu_op_q      <= ALU_ADD;
      alu_src_imm_q <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_dst_rd_q  <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          ir_q    <= inst;
          pc_q    <= pc_q + PC_W'(1);
          state_q <= DECODE;
        end
        DECODE: begin
          if (illegal) begin
            halt_q  <= 1'b1;
            state_q <= TRAP;
          end else if (cls == CLS_NOP) begin
            state_q <= FETCH;
          end else begin
            alu_op_q      <= (cls == CLS_AND) ? ALU_AND :
                             (cls == CLS_BEQ) ? ALU_SUB : ALU_ADD;
            alu_src_imm_q <= (cls == CLS_ADDI) || (cls == CLS_LOAD);
            state_q       <= EXEC;
          end
        end
        EXEC: begin
          alu_op_q      <= ALU_ADD;
          alu_src_imm_q <= 1'b0;
          case (cls)
            CLS_BEQ: begin
              // Offset is relative to the already-incremented PC.
              if (alu_zero) pc_q <= pc_q + ir_q[10 +: PC_W];
              state_q <= FETCH;
            end
            CLS_J: begin
              pc_q    <= ir_q[PC_W-1:0];
              state_q <= FETCH;
            end
            CLS_LOAD: begin
              mem_req_q <= 1'b1;
              state_q   <= MEM;
            end
            default: begin
              reg_write_q  <= 1'b1;
              reg_dst_rd_q <= (cls != CLS_ADDI);
              mem_to_reg_q <= 1'b0;
              state_q      <= WB;
            end
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            reg_write_q  <= 1'b1;
            reg_dst_rd_q <= 1'b0;
            mem_to_reg_q <= 1'b1;
            state_q      <= WB;
          end
        end
        WB: begin
          reg_write_q  <= 1'b0;
          reg_dst_rd_q <= 1'b0;
          mem_to_reg_q <= 1'b0;
          state_q      <= FETCH;
        end
        TRAP: state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign inst_addr   = pc_q;
  assign rs          = ir_q[9:5];
  assign rt          = ir_q[4:0];
  assign rd          = ir_q[14:10];
  assign imm         = ir_q[10 +: IMM_W];
  assign alu_op      = alu_op_q;
  assign alu_src_imm = alu_src_imm_q;
  assign reg_write   = reg_write_q;
  assign reg_dst_rd  = reg_dst_rd_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign mem_req     = mem_req_q;
  assign halt        = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl : instruction-level reference model bench    | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  localparam int K_NOP  = 0;
  localparam int K_ADD  = 1;
  localparam int K_AND  = 2;
  localparam int K_ADDI = 3;
  localparam int K_BEQ  = 4;
  localparam int K_J    = 5;
  localparam int K_LOAD = 6;
  localparam int K_ILL  = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  inst_addr;
  logic [31:0] inst;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [1:0]  alu_op;
  logic        alu_src_imm, reg_write, reg_dst_rd, mem_to_reg, mem_req, halt;

  logic [31:0] rom [64];
  int checks = 0;
  int errors = 0;

  assign inst = rom[inst_addr];

  always #5 clk = ~clk;

  multicycle_ctrl #(.PC_W(6), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst(inst),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg), .mem_req(mem_req),
    .halt(halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] w);
    case (w[31:26])
      6'h00:   return (w[25:20] == 6'h01) ? K_ADD : (w[25:20] == 6'h00) ? K_NOP : K_ILL;
      6'h01:   return K_AND;
      6'h05:   return K_ADDI;
      6'h0F:   return K_BEQ;
      6'h12:   return K_J;
      6'h0D:   return K_LOAD;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0:       return {6'h00, 6'h00, r[19:0]};
      1:       return {6'h00, 6'h01, r[19:0]};
      2:       return {6'h01, r[25:0]};
      3:       return {6'h05, r[25:0]};
      4:       return {6'h0F, r[25:0]};
      5:       return {6'h12, r[25:0]};
      default: return {6'h0D, r[25:0]};
    endcase
  endfunction

  // Leaves the bench at a falling edge with the DUT sitting in FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("rst_addr", inst_addr, 0);
    chk("rst_strb", {halt, reg_write, mem_req, reg_dst_rd, mem_to_reg, alu_src_imm}, 0);
    chk("rst_ir", {rs, rt, rd, imm, alu_op}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected behaviour of one instruction, cycle by cycle, starting in FETCH.
  // zsel: -1 random alu_zero, else forced. ackn: 0 random MEM length, else N.
  task automatic run_instr(input logic [5:0] pc, input int zsel, input int ackn,
                           output logic [5:0] npc, output bit halted);
    logic [31:0] w;
    int          k, n;
    logic        z;
    w = rom[pc];
    k = kind_of(w);
    npc = pc + 6'd1;
    halted = 1'b0;

    chk("fetch_addr", inst_addr, pc);
    chk("fetch_strb", {halt, reg_write, mem_req}, 0);
    mem_ack  = 1'($urandom);
    alu_zero = 1'($urandom);
    @(negedge clk);

    chk("dec_addr", inst_addr, npc);
    chk("dec_strb", {halt, reg_write, mem_req}, 0);
    chk("dec_fields", {rs, rt, rd, imm}, {w[9:5], w[4:0], w[14:10], w[25:10]});
    @(negedge clk);

    if (k == K_ILL) begin
      chk("trap_halt", halt, 1);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("trap_hold", {inst_addr, halt, reg_write, mem_req}, {npc, 3'b100});
      end
      halted = 1'b1;
      return;
    end
    if (k == K_NOP) return;

    if (k != K_J)
      chk("exec_alu", {alu_op, alu_src_imm},
          {(k == K_AND) ? 2'd1 : (k == K_BEQ) ? 2'd2 : 2'd0, (k == K_ADDI) || (k == K_LOAD)});
    chk("exec_strb", {halt, reg_write, mem_req}, 0);
    if (k == K_BEQ) begin
      z = (zsel < 0) ? 1'($urandom) : (zsel != 0);
      alu_zero = z;
      if (z) npc = npc + w[15:10];
    end
    if (k == K_J) npc = w[5:0];
    @(negedge clk);
    if (k == K_BEQ || k == K_J) return;

    if (k == K_LOAD) begin
      n = (ackn > 0) ? ackn : $urandom_range(1, 4);
      for (int i = 1; i <= n; i++) begin
        chk("mem_req", {mem_req, reg_write, rs, rt, imm}, {2'b10, w[9:5], w[4:0], w[25:10]});
        mem_ack = (i == n);
        @(negedge clk);
      end
    end

    chk("wb_ctrl", {reg_write, reg_dst_rd, mem_to_reg, mem_req},
        {1'b1, (k == K_ADD) || (k == K_AND), k == K_LOAD, 1'b0});
    chk("wb_fields", {rd, rt}, {w[14:10], w[4:0]});
    mem_ack = 1'($urandom);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] pc, npc;
    bit         h;

    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h0000_0000;                                   // NOP
    rom[1] = {6'h00, 6'h01, 5'd0, 5'd1, 5'd2, 5'd3};          // ADD rd=1
    rom[2] = {6'h01, 6'h00, 5'd0, 5'd4, 5'd5, 5'd6};          // AND rd=4
    rom[3] = {6'h0F, 10'h000, 6'd1, 5'd2, 5'd3};              // BEQ +1
    rom[4] = {6'h05, 16'h0007, 5'd2, 5'd7};                   // ADDI
    rom[5] = {6'h12, 20'h0, 6'h01};                           // J 1
    rom[6] = {6'h00, 6'h01, 5'd0, 5'd9, 5'd3, 5'd4};          // ADD
    rom[7] = {6'h0D, 16'hFFF5, 5'd8, 5'd1};                   // LOAD

    // Program walk: BEQ taken on the first pass, not taken on the second.
    do_reset();
    pc = 6'd0;
    for (int i = 0; i < 10; i++) begin
      run_instr(pc, (i < 5) ? 1 : 0, 1, npc, h);
      pc = npc;
    end

    // LOAD at 7 with a three-cycle memory wait.
    do_reset();
    rom[0] = {6'h12, 20'h0, 6'h07};
    run_instr(6'd0, 0, 0, npc, h);
    run_instr(npc, 0, 3, npc, h);
    run_instr(npc, 0, 0, npc, h);

    // PC wrap from 0x3F.
    do_reset();
    rom[0]  = {6'h12, 20'h0, 6'h3F};
    rom[63] = 32'h0;
    run_instr(6'd0, 0, 0, npc, h);
    run_instr(npc, 0, 0, npc, h);
    run_instr(npc, 0, 0, npc, h);

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    rom[0] = {6'h0D, 16'h0003, 5'd8, 5'd1};
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {mem_req, inst_addr, halt}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Random legal programs against the model.
    do_reset();
    for (int i = 0; i < 64; i++) rom[i] = rand_legal();
    pc = 6'd0;
    for (int i = 0; i < 300; i++) begin
      run_instr(pc, -1, 0, npc, h);
      pc = npc;
    end

    // Illegal opcode, then an illegal R-type func.
    rom[pc] = {6'h3F, 26'($urandom)};
    run_instr(pc, -1, 0, npc, h);
    do_reset();
    rom[0] = {6'h00, 6'h2A, 20'($urandom)};
    run_instr(6'd0, -1, 0, npc, h);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle fetch/sequencing controller for the 6-bit-addressed combinational instruction ROM and the single-ALU datapath. Owns the PC and instruction register. Runs a per-instruction FSM (fetch, decode, execute, memory, writeback) and drives ALU and register-file control. Runs a request/acknowledge handshake with data memory for loads.

Parameters:
PC_W, 6, ROM address / PC width (64 words)
IMM_W, 16, immediate width taken from inst[25:10]

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
inst_addr  out  PC_W  ROM address, equal to the PC register
inst  in  32  ROM data (combinational from inst_addr)
alu_zero  in  1  ALU zero flag, valid in EXEC
mem_ack  in  1  data memory done; read data valid this cycle
rs  out  5  IR[9:5]
rt  out  5  IR[4:0]
rd  out  5  IR[14:10]
imm  out  IMM_W  IR[25:10]
alu_op  out  2  0=ADD 1=AND 2=SUB
alu_src_imm  out  1  ALU operand B = sign-extended imm
reg_write  out  1  register-file write strobe, one cycle
reg_dst_rd  out  1  1: write rd, 0: write rt
mem_to_reg  out  1  writeback data from memory
mem_req  out  1  load request
halt  out  1  illegal opcode trapped; sticky

Behaviour:
- Reset (async, immediate): PC=0, IR=0, state=FETCH, all strobes 0, halt=0, mem_req drops the same instant.
- Decode uses IR[31:26] (op) and IR[25:20] (func):
  - op 000000 func 000001: ADD
  - op 000000 func 000000: NOP
  - op 000001: AND
  - op 000101: ADDI
  - op 001111: BEQ
  - op 010010: J
  - op 001101: LOAD
  - any other op/func: illegal
- FETCH (1 cycle): IR<=inst; PC<=PC+1, 6-bit wrap so 0x3F -> 0x00; next DECODE.
- DECODE (1 cycle): register-file read; illegal -> TRAP; NOP -> FETCH; otherwise EXEC.
- EXEC (1 cycle), outputs per instruction:
  - ADD: alu_op=ADD, alu_src_imm=0
  - AND: alu_op=AND, alu_src_imm=0
  - ADDI: alu_op=ADD, alu_src_imm=1
  - LOAD: alu_op=ADD, alu_src_imm=1 (address = rs + sext(imm))
  - BEQ: alu_op=SUB on rs,rt; if alu_zero then PC<=PC+imm[5:0] (already-incremented PC, mod 64)
  - J: PC<=IR[5:0]
- EXEC next state: BEQ/J -> FETCH; LOAD -> MEM; others -> WB.
- MEM: mem_req=1 while in MEM. Stay until mem_ack=1, then WB. mem_ack seen in the first MEM cycle is legal (minimum 1 cycle). mem_ack outside MEM is ignored.
- WB (1 cycle), reg_write=1:
  - ADD/AND: reg_dst_rd=1, mem_to_reg=0
  - ADDI: reg_dst_rd=0, mem_to_reg=0
  - LOAD: reg_dst_rd=0, mem_to_reg=1
  - next FETCH.
- TRAP: halt=1, all strobes 0, PC frozen; exit only by rst.
- Latency in cycles: NOP 2; BEQ/J 3; ADD/AND/ADDI 4; LOAD 4+N, where N>=1 is cycles in MEM.
- Strobes (reg_write, mem_req) are Moore outputs of state+IR and glitch-free relative to clk.
- rs/rt/rd/imm come from IR, not from inst, so they are stable across the whole instruction.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_AND, OP_ADDI, OP_BEQ, OP_J, OP_LOAD
  - func constants: FN_NOP, FN_ADD
  - alu_op encodings
  - state enum: FETCH, DECODE, EXEC, MEM, WB, TRAP
- One sub-module, ctrl_decode: purely combinational IR -> instruction class, including the illegal flag. The FSM and PC/IR registers stay in multicycle_ctrl.

Test Plan:
- Reset then free-run over the team's standard 8-word ROM program, mem_ack tied high:
  - addr 0 NOP: 2 cycles.
  - addr 1 ADD: reg_write with rd=1, reg_dst_rd=1 on cycle 4 of the instruction.
  - addr 2 AND: rd=4.
- BEQ at addr 3 with alu_zero=1 -> next fetch at inst_addr=5 (4 skipped). With alu_zero=0 -> next fetch at 4.
- J at addr 5 (target 0x01) -> next fetch inst_addr=1; IR/PC trace repeats.
- LOAD at addr 7 with mem_ack delayed 3 cycles:
  - mem_req high exactly 3 cycles with imm=0xFFF5, rs=8, rt=1.
  - then one reg_write with mem_to_reg=1, reg_dst_rd=0.
- Illegal op 0x3F in ROM -> halt=1 after DECODE; inst_addr frozen and no strobes for 20 cycles. rst clears halt and PC=0.
- rst asserted mid-MEM (between clock edges) -> mem_req=0 and inst_addr=0 immediately. PC at 0x3F with a NOP -> next fetch address 0x00.
